// File: rtl/gcbp_frame_ctrl_pkg.sv
// Shared constants, address layout and state encodings for the GCBP frame controller.
// The FSM encodings are also read by the line generator for debug.
package gcbp_frame_ctrl_pkg;

  localparam int BRAM_DATA_WIDTH             = 128;
  localparam int C_SUBIMAGE_WIDTH            = BRAM_DATA_WIDTH;
  localparam int C_SUBIMAGE_HEIGHT           = 128;
  localparam int C_NUM_VERT_SUBIMAGES        = 2;
  localparam int C_LINES_PER_FRAME           = 480;
  localparam int C_VERT_EDGE_TO_SUBIMAGE     = 75;
  localparam int C_VERT_SUBIMAGE_TO_SUBIMAGE = 74;

  localparam int NUM_BANKS  = 2;
  localparam int LINE_CNT_W = 9;
  localparam int DROP_W     = 8;
  localparam int HSUB_W     = 2;

  // BRAM address: {bank, vsub, hsub[1:0], row[6:0]}
  localparam int ADDR_W   = 11;
  localparam int ROW_LSB  = 0;
  localparam int ROW_W    = 7;
  localparam int HSUB_LSB = 7;
  localparam int VSUB_LSB = 9;
  localparam int VSUB_W   = 1;
  localparam int BANK_LSB = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SKIP    = 3'd1,
    S_GAP     = 3'd2,
    S_CAPTURE = 3'd3,
    S_TAIL    = 3'd4
  } frame_state_e;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic              bank,
    input logic [VSUB_W-1:0] vsub,
    input logic [HSUB_W-1:0] hsub,
    input logic [ROW_W-1:0]  row
  );
    logic [ADDR_W-1:0] a;
    a                          = '0;
    a[BANK_LSB]                = bank;
    a[VSUB_LSB +: VSUB_W]      = vsub;
    a[HSUB_LSB +: HSUB_W]      = hsub;
    a[ROW_LSB +: ROW_W]        = row;
    return a;
  endfunction

endpackage

// File: rtl/gcbp_frame_ctrl_if.sv
// Line-generator, BRAM write and consumer handshake signals of the frame controller.
// master = surrounding capture path / consumer, slave = gcbp_frame_ctrl.
interface gcbp_frame_ctrl_if
  import gcbp_frame_ctrl_pkg::*;
#(
  parameter int W = C_SUBIMAGE_WIDTH
) ();

  logic              i_frame_start;
  logic              i_line_start;
  logic [W-1:0]      i_gcbp_line;
  logic              i_gcbp_line_valid;
  logic [HSUB_W-1:0] i_hori_subimage_cnt;
  logic              i_bank_release;

  logic              o_line_ready;
  logic              o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [W-1:0]      o_bram_wdata;
  logic              o_bank_valid;
  logic              o_bank_id;
  logic [DROP_W-1:0] o_dropped_frames;

  modport master (
    output i_frame_start, i_line_start, i_gcbp_line, i_gcbp_line_valid,
           i_hori_subimage_cnt, i_bank_release,
    input  o_line_ready, o_bram_we, o_bram_addr, o_bram_wdata,
           o_bank_valid, o_bank_id, o_dropped_frames
  );

  modport slave (
    input  i_frame_start, i_line_start, i_gcbp_line, i_gcbp_line_valid,
           i_hori_subimage_cnt, i_bank_release,
    output o_line_ready, o_bram_we, o_bram_addr, o_bram_wdata,
           o_bank_valid, o_bank_id, o_dropped_frames
  );

endinterface

// File: rtl/gcbp_frame_ctrl_bank_tracker.sv
// Ping-pong bank ownership: per-bank FREE/FILLING/FULL state plus the 2-deep FIFO
// of full banks waiting for the consumer.
module gcbp_bank_tracker
  import gcbp_frame_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic claim_i,
  input  logic abort_i,
  input  logic publish_i,
  input  logic release_i,
  output logic claim_ok_o,
  output logic wr_bank_o,
  output logic bank_valid_o,
  output logic bank_id_o
);

  bank_state_e          bank_q [NUM_BANKS];
  bank_state_e          bank_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] free_now;
  logic                 wr_bank_q, wr_bank_d;
  logic                 claim_id;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 do_release;

  // A bank counts as free this cycle if a release or an abort hands it back now.
  always_comb begin
    do_release = release_i && (cnt_q != 2'd0);
    for (int b = 0; b < NUM_BANKS; b++) begin
      free_now[b] = (bank_q[b] == BANK_FREE)
                 || (do_release && (head_q == 1'(b)))
                 || (abort_i && (wr_bank_q == 1'(b)) && (bank_q[b] == BANK_FILLING));
    end
    claim_ok_o = |free_now;
    claim_id   = ~free_now[0];
  end

  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    if (do_release) begin
      bank_d[head_q] = BANK_FREE;
      head_d         = tail_q;
      cnt_d          = cnt_q - 2'd1;
    end
    if (abort_i && (bank_q[wr_bank_q] == BANK_FILLING)) begin
      bank_d[wr_bank_q] = BANK_FREE;
    end
    if (publish_i) begin
      bank_d[wr_bank_q] = BANK_FULL;
      if (cnt_d == 2'd0) begin
        head_d = wr_bank_q;
      end else begin
        tail_d = wr_bank_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
    if (claim_i && claim_ok_o) begin
      bank_d[claim_id] = BANK_FILLING;
      wr_bank_d        = claim_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= BANK_FREE;
      end
      wr_bank_q <= 1'b0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_bank_o    = wr_bank_q;
  assign bank_valid_o = (cnt_q != 2'd0);
  assign bank_id_o    = head_q;

endmodule

// File: rtl/gcbp_frame_ctrl.sv
// GCBP frame controller: line counting, band gating of the line generator,
// BRAM write addressing and ping-pong bank hand-off to the matcher.
//
//   state     | meaning
//   S_IDLE    | no frame seen since reset
//   S_SKIP    | frame dropped, no free bank; wait for next frame start
//   S_GAP     | frame in progress, current line outside a band
//   S_CAPTURE | frame in progress, current line inside a band
//   S_TAIL    | frame complete and published; wait for next frame start
module gcbp_frame_ctrl
  import gcbp_frame_ctrl_pkg::*;
#(
  parameter int C_SUBIMAGE_WIDTH            = BRAM_DATA_WIDTH,
  parameter int C_SUBIMAGE_HEIGHT           = gcbp_frame_ctrl_pkg::C_SUBIMAGE_HEIGHT,
  parameter int C_NUM_VERT_SUBIMAGES        = gcbp_frame_ctrl_pkg::C_NUM_VERT_SUBIMAGES,
  parameter int C_LINES_PER_FRAME           = gcbp_frame_ctrl_pkg::C_LINES_PER_FRAME,
  parameter int C_VERT_EDGE_TO_SUBIMAGE     = gcbp_frame_ctrl_pkg::C_VERT_EDGE_TO_SUBIMAGE,
  parameter int C_VERT_SUBIMAGE_TO_SUBIMAGE = gcbp_frame_ctrl_pkg::C_VERT_SUBIMAGE_TO_SUBIMAGE
) (
  input logic              i_clk,
  input logic              i_reset,
  gcbp_frame_ctrl_if.slave bus
);

  frame_state_e                state_q, state_d;
  logic [LINE_CNT_W-1:0]       line_cnt_q, line_cnt_d, line_use;
  logic [VSUB_W-1:0]           band_q, band_d, line_band;
  logic [ROW_W-1:0]            row_q, row_d, line_row;
  logic                        line_in_band;
  logic [DROP_W-1:0]           drops_q, drops_d;
  logic                        we_q, we_d;
  logic                        last_q, last_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [C_SUBIMAGE_WIDTH-1:0] wdata_q;
  logic                        final_write;
  logic                        claim, abort, claim_ok;
  logic                        wr_bank, bank_valid, bank_id;

  function automatic int band_start(input int k);
    return C_VERT_EDGE_TO_SUBIMAGE + k * (C_SUBIMAGE_HEIGHT + C_VERT_SUBIMAGE_TO_SUBIMAGE);
  endfunction

  // A frame start in the same cycle as a line start makes that line number 0.
  assign line_use = bus.i_frame_start ? '0 : line_cnt_q;

  always_comb begin
    line_in_band = 1'b0;
    line_band    = '0;
    line_row     = '0;
    for (int k = 0; k < C_NUM_VERT_SUBIMAGES; k++) begin
      if ((int'(line_use) >= band_start(k)) &&
          (int'(line_use) < band_start(k) + C_SUBIMAGE_HEIGHT)) begin
        line_in_band = 1'b1;
        line_band    = VSUB_W'(k);
        line_row     = ROW_W'(int'(line_use) - band_start(k));
      end
    end
  end

  always_comb begin
    line_cnt_d = line_use;
    band_d     = band_q;
    row_d      = row_q;
    if (bus.i_frame_start || bus.i_line_start) begin
      band_d = line_band;
      row_d  = line_row;
    end
    if (bus.i_line_start && (line_use != LINE_CNT_W'(C_LINES_PER_FRAME - 1))) begin
      line_cnt_d = line_use + LINE_CNT_W'(1);
    end
  end

  assign final_write = (band_q == VSUB_W'(C_NUM_VERT_SUBIMAGES - 1))
                    && (row_q == ROW_W'(C_SUBIMAGE_HEIGHT - 1))
                    && (bus.i_hori_subimage_cnt == 2'd3);

  always_comb begin
    state_d = state_q;
    drops_d = drops_q;
    claim   = 1'b0;
    abort   = 1'b0;
    if (bus.i_frame_start) begin
      abort = (state_q == S_GAP) || (state_q == S_CAPTURE);
      if (claim_ok) begin
        claim   = 1'b1;
        state_d = line_in_band ? S_CAPTURE : S_GAP;
      end else begin
        state_d = S_SKIP;
        if (drops_q != '1) begin
          drops_d = drops_q + DROP_W'(1);
        end
      end
    end else if ((state_q == S_CAPTURE) && bus.i_gcbp_line_valid && final_write) begin
      state_d = S_TAIL;
    end else if (bus.i_line_start && ((state_q == S_GAP) || (state_q == S_CAPTURE))) begin
      state_d = line_in_band ? S_CAPTURE : S_GAP;
    end
  end

  // The final write is published one cycle after it appears on the BRAM port,
  // unless a new frame start preempted it.
  always_comb begin
    we_d   = (state_q == S_CAPTURE) && bus.i_gcbp_line_valid;
    last_d = we_d && final_write && !bus.i_frame_start;
    addr_d = pack_addr(wr_bank, band_q, bus.i_hori_subimage_cnt, row_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      line_cnt_q <= '0;
      band_q     <= '0;
      row_q      <= '0;
      drops_q    <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      band_q     <= band_d;
      row_q      <= row_d;
      drops_q    <= drops_d;
      we_q       <= we_d;
      last_q     <= last_d;
      if (we_d) begin
        addr_q  <= addr_d;
        wdata_q <= bus.i_gcbp_line;
      end
    end
  end

  gcbp_bank_tracker u_bank_tracker (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .claim_i      (claim),
    .abort_i      (abort),
    .publish_i    (we_q && last_q),
    .release_i    (bus.i_bank_release),
    .claim_ok_o   (claim_ok),
    .wr_bank_o    (wr_bank),
    .bank_valid_o (bank_valid),
    .bank_id_o    (bank_id)
  );

  assign bus.o_line_ready     = bus.i_line_start && line_in_band
                             && ((state_q == S_GAP) || (state_q == S_CAPTURE));
  assign bus.o_bram_we        = we_q;
  assign bus.o_bram_addr      = addr_q;
  assign bus.o_bram_wdata     = wdata_q;
  assign bus.o_bank_valid     = bank_valid;
  assign bus.o_bank_id        = bank_id;
  assign bus.o_dropped_frames = drops_q;

endmodule

// File: tb/tb_gcbp_frame_ctrl.sv
// Directed bench for gcbp_frame_ctrl: scoreboarded BRAM writes, band gating,
// ping-pong/skip, abort, simultaneous release/start and mid-frame reset.
module tb_gcbp_frame_ctrl;
  import gcbp_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcbp_frame_ctrl_if bus ();
  gcbp_frame_ctrl dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int           nvec = 0;
  int           nerr = 0;
  logic [138:0] sb [$];
  logic [138:0] sb_exp;
  int           bank_m [$];
  int           wr_cnt = 0;
  int           lr_cnt = 0;
  int           wr_base;
  logic [10:0]  last_addr = '0;
  logic [10:0]  first_addr = '0;
  bit           want_first = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_in_band(input int l);
    return ((l >= 75) && (l <= 202)) || ((l >= 277) && (l <= 404));
  endfunction

  function automatic logic [10:0] tb_addr(input bit bank, input int l, input int h);
    int band;
    int row;
    logic [10:0] a;
    band = (l >= 277) ? 1 : 0;
    row  = l - ((band == 1) ? 277 : 75);
    a    = {bank, band[0], h[1:0], row[6:0]};
    return a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Writes appear one cycle after the valid that caused them; pop in order.
  always @(negedge clk) begin
    if (bus.o_bram_we === 1'b1) begin
      wr_cnt++;
      last_addr = bus.o_bram_addr;
      if (want_first) begin
        first_addr = bus.o_bram_addr;
        want_first = 1'b0;
      end
      nvec++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_write: observed addr %h, expected no write", bus.o_bram_addr);
      end
      if (sb.size() != 0) begin
        sb_exp = sb.pop_front();
        nvec++;
        assert ({bus.o_bram_addr, bus.o_bram_wdata} === sb_exp) else begin
          nerr++;
          $error("FAIL bram_write: observed %h/%h expected %h/%h", bus.o_bram_addr,
                 bus.o_bram_wdata, sb_exp[138:128], sb_exp[127:0]);
        end
      end
    end
  end

  task automatic drive(input bit fs, input bit ls, input bit v, input bit rel,
                       input int h, input logic [127:0] d);
    @(negedge clk);
    bus.i_frame_start       = fs;
    bus.i_line_start        = ls;
    bus.i_gcbp_line_valid   = v;
    bus.i_bank_release      = rel;
    bus.i_hori_subimage_cnt = 2'(h);
    bus.i_gcbp_line         = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic check_banks(input string tag);
    chk({tag, "_bank_valid"}, bus.o_bank_valid, bank_m.size() != 0);
    if (bank_m.size() != 0) chk({tag, "_bank_id"}, bus.o_bank_id, bank_m[0]);
  endtask

  task automatic frame_start(input bit rel);
    drive(1'b1, 1'b0, 1'b0, rel, 0, '0);
    if (rel && (bank_m.size() != 0)) void'(bank_m.pop_front());
  endtask

  task automatic run_lines(input int first, input int last, input bit cap, input bit bank);
    logic [127:0] d;
    for (int l = first; l <= last; l++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
      #1;
      chk($sformatf("line_ready_l%0d", l), bus.o_line_ready, cap && tb_in_band(l));
      if (bus.o_line_ready === 1'b1) lr_cnt++;
      if (tb_in_band(l) || (l == 210)) begin
        for (int h = 0; h < 4; h++) begin
          d = rnd128();
          drive(1'b0, 1'b0, 1'b1, 1'b0, h, d);
          if (cap && tb_in_band(l)) sb.push_back({tb_addr(bank, l, h), d});
        end
      end
      if (cap && (l == 404)) begin
        idle();
        #1;
        chk("last_write_addr", last_addr, {bank, 10'h3FF});
        check_banks("pre_publish");
        bank_m.push_back(int'(bank));
        idle();
        #1;
        check_banks("post_publish");
      end
    end
  endtask

  task automatic full_frame(input bit cap, input bit bank, input bit rel, input string tag);
    idle();
    #1;
    lr_cnt     = 0;
    wr_base    = wr_cnt;
    want_first = cap;
    frame_start(rel);
    run_lines(0, 479, cap, bank);
    idle();
    idle();
    #1;
    chk({tag, "_line_ready_pulses"}, lr_cnt, cap ? 256 : 0);
    chk({tag, "_writes"}, wr_cnt - wr_base, cap ? 1024 : 0);
    if (cap) chk({tag, "_first_addr"}, first_addr, {bank, 10'h000});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_line_ready"}, bus.o_line_ready, 1'b0);
    chk({tag, "_bram_we"}, bus.o_bram_we, 1'b0);
    chk({tag, "_bram_addr"}, bus.o_bram_addr, 11'h000);
    chk({tag, "_bram_wdata"}, bus.o_bram_wdata, 128'h0);
    chk({tag, "_bank_valid"}, bus.o_bank_valid, 1'b0);
    chk({tag, "_bank_id"}, bus.o_bank_id, 1'b0);
    chk({tag, "_dropped"}, bus.o_dropped_frames, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_frame_start       = 1'b0;
    bus.i_line_start        = 1'b0;
    bus.i_gcbp_line_valid   = 1'b0;
    bus.i_bank_release      = 1'b0;
    bus.i_hori_subimage_cnt = 2'd0;
    bus.i_gcbp_line         = '0;
    idle();
    idle();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Frame aborted at line 300, then the restarted frame reuses bank 0 from row 0.
    idle();
    frame_start(1'b0);
    run_lines(0, 299, 1'b1, 1'b0);
    idle();
    #1;
    check_banks("abort_partial");
    full_frame(1'b1, 1'b0, 1'b0, "frame_a");
    check_banks("frame_a_end");

    full_frame(1'b1, 1'b1, 1'b0, "frame_b");
    check_banks("frame_b_end");

    full_frame(1'b0, 1'b0, 1'b0, "frame_skip");
    chk("dropped_after_skip", bus.o_dropped_frames, 8'd1);
    check_banks("skip_end");

    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, '0);
    void'(bank_m.pop_front());
    idle();
    #1;
    check_banks("after_release");

    full_frame(1'b1, 1'b0, 1'b0, "frame_c");
    check_banks("frame_c_end");

    // Both banks full: release and frame start together; bank 1 is freed and claimed.
    idle();
    frame_start(1'b1);
    run_lines(0, 100, 1'b1, 1'b1);
    idle();
    #1;
    chk("dropped_after_simul", bus.o_dropped_frames, 8'd1);
    check_banks("simul");

    // Reset during capture, with a valid in the same cycle that must be lost.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, rnd128());
    rst = 1'b1;
    idle();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bank_m.delete();

    idle();
    frame_start(1'b0);
    run_lines(0, 80, 1'b1, 1'b0);
    idle();
    idle();
    #1;
    check_banks("post_reset_frame");
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
